// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage state encoding and default widths
package pipe_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned IF_ID_WIDTH = 64;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_FULL  = 2'd1,
      PS_SKID  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - second-entry holding register for the skid build of pipe_stage_reg
module pipe_skid_buf #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic             i_unload,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Capture the overflow word when main is stalled; drop it on reset/flush or once moved to main
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_unload) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline register with flush, freeze and stall counter; PIPE_STAGE_SKID_EN selects the skid build
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       WIDTH       = IF_ID_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
   parameter int unsigned       CNT_WIDTH   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [WIDTH-1:0]     i_in_data,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [WIDTH-1:0]     o_out_data,
   input  logic                 i_flush,
   input  logic                 i_busy_wait,
   output logic [CNT_WIDTH-1:0] o_stall_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   pipe_state_e          r_state;
   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_out_data;
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic                 w_in_xfer;
   logic                 w_out_xfer;

   // A frozen stage must not present its word, but keeps it in the register
   assign o_out_valid = r_out_valid && !i_busy_wait;
   assign o_out_data  = r_out_data;
   assign o_stall_cnt = r_stall_cnt;
   assign w_in_xfer   = i_in_valid && o_in_ready;
   assign w_out_xfer  = o_out_valid && i_out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic             w_skid_valid;
   logic [WIDTH-1:0] w_skid_data;
   logic             w_skid_load;
   logic             w_skid_unload;

   // Ready depends only on held state, so OUT_READY never reaches IN_READY
   assign o_in_ready    = !i_reset && !i_busy_wait && (r_state != PS_SKID);
   assign w_skid_load   = !i_flush && (r_state == PS_FULL) && w_in_xfer && !w_out_xfer;
   assign w_skid_unload = !i_flush && (r_state == PS_SKID) && w_out_xfer;

   pipe_skid_buf #(
      .WIDTH (WIDTH)
   ) u_skid (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (i_flush),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_data   (i_in_data),
      .o_valid  (w_skid_valid),
      .o_data   (w_skid_data)
   );

   // Main register and occupancy state; skid word is promoted when main drains
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_state     <= PS_EMPTY;
         r_out_valid <= 1'b0;
         r_out_data  <= RESET_VALUE;
      end else if (!i_busy_wait) begin
         case (r_state)
            PS_EMPTY: begin
               if (w_in_xfer) begin
                  r_out_data  <= i_in_data;
                  r_out_valid <= 1'b1;
                  r_state     <= PS_FULL;
               end
            end
            PS_FULL: begin
               if (w_in_xfer && w_out_xfer) begin
                  r_out_data <= i_in_data;
               end else if (w_in_xfer) begin
                  r_state <= PS_SKID;
               end else if (w_out_xfer) begin
                  r_out_valid <= 1'b0;
                  r_state     <= PS_EMPTY;
               end
            end
            PS_SKID: begin
               if (w_out_xfer && w_skid_valid) begin
                  r_out_data <= w_skid_data;
                  r_state    <= PS_FULL;
               end
            end
            default: begin
               r_state     <= PS_EMPTY;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end
`else
   // Single-entry build: a full stage can only accept when the word leaves this cycle
   assign o_in_ready = !i_reset && !i_busy_wait && ((r_state == PS_EMPTY) || i_out_ready);

   // Main register and occupancy state; a simultaneous transfer replaces the held word
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_state     <= PS_EMPTY;
         r_out_valid <= 1'b0;
         r_out_data  <= RESET_VALUE;
      end else if (!i_busy_wait) begin
         if (w_in_xfer) begin
            r_out_data  <= i_in_data;
            r_out_valid <= 1'b1;
            r_state     <= PS_FULL;
         end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= PS_EMPTY;
         end
      end
   end
`endif

   // Saturating count of cycles where the stage holds a word downstream refuses, or is frozen
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stall_cnt <= '0;
      end else if (((r_out_valid && !i_out_ready) || i_busy_wait) && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue-based reference model
module tb_pipe_stage_reg;

   localparam logic [63:0] RV = 64'hDEAD_BEEF_0000_0001;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic        busy = 1'b0;

   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic [15:0] stall_cnt;

   logic        in_ready2;
   logic        out_valid2;
   logic [63:0] out_data2;
   logic [1:0]  stall_cnt2;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] q[$];
   logic [63:0] m_data = RV;
   int unsigned m_cnt = 0;
   bit          m_known = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(64), .RESET_VALUE(RV), .CNT_WIDTH(16)) dut (
      .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_data(out_data), .i_flush(flush), .i_busy_wait(busy), .o_stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.WIDTH(64), .RESET_VALUE(RV), .CNT_WIDTH(2)) dut_sat (
      .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready2),
      .i_in_data(in_data), .o_out_valid(out_valid2), .i_out_ready(out_ready),
      .o_out_data(out_data2), .i_flush(flush), .i_busy_wait(busy), .o_stall_cnt(stall_cnt2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_in_ready();
      if (reset || busy) return 1'b0;
      if (CAP == 2) return q.size() < 2;
      return (q.size() == 0) || out_ready;
   endfunction

   task automatic step(input bit rst, input bit iv, input logic [63:0] id,
                       input bit ordy, input bit fl, input bit bw);
      bit ix;
      bit ox;
      reset = rst; in_valid = iv; in_data = id; out_ready = ordy; flush = fl; busy = bw;
      #1;
      if (m_known) begin
         chk("in_ready",  {63'd0, in_ready},  {63'd0, exp_in_ready()});
         chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0) && !busy});
         chk("out_data",  out_data, m_data);
         chk("stall_cnt", {48'd0, stall_cnt}, (m_cnt > 65535) ? 64'd65535 : 64'(m_cnt));
         chk("stall_sat", {62'd0, stall_cnt2}, (m_cnt > 3) ? 64'd3 : 64'(m_cnt));
         chk("out_valid_sat", {63'd0, out_valid2}, {63'd0, (q.size() > 0) && !busy});
      end
      ix = iv && exp_in_ready();
      ox = (q.size() > 0) && !bw && ordy;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_data  = RV;
         m_cnt   = 0;
         m_known = 1'b1;
      end else begin
         if (((q.size() > 0) && !ordy) || bw) m_cnt++;
         if (fl) begin
            q.delete();
            m_data = RV;
         end else if (!bw) begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(id);
            if (q.size() > 0) m_data = q[0];
         end
      end
      @(negedge clk);
   endtask

   initial begin
      // reset
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      // streaming 0..7 with OUT_READY high
      for (int i = 0; i < 8; i++) step(0, 1, 64'(i), 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      // backpressure: 0xA then 0xB with OUT_READY low, then release
      step(0, 1, 64'hA, 0, 0, 0);
      step(0, 1, 64'hB, 0, 0, 0);
      step(0, 1, 64'hB, 0, 0, 0);
      step(0, 1, 64'hB, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      // flush while holding words, with a same-cycle input of 0x3
      step(0, 1, 64'h1, 0, 0, 0);
      step(0, 1, 64'h2, 0, 0, 0);
      step(0, 1, 64'h3, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      // BUSY_WAIT for 3 cycles holding 0x55
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 64'h55, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 64'h66, 1, 0, 1);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      // flush together with BUSY_WAIT
      step(0, 1, 64'h77, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0, 0);
      // saturation: valid word with OUT_READY low for 6 cycles
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 64'h99, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
      // mid-operation reset while FULL
      step(1, 1, 64'h12, 0, 0, 0);
      step(0, 1, 64'h13, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(99, 0) < 2,
              $urandom_range(99, 0) < 70,
              {$urandom, $urandom},
              $urandom_range(99, 0) < 60,
              $urandom_range(99, 0) < 5,
              $urandom_range(99, 0) < 10);
      end
      step(0, 0, 0, 1, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
